cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control unit that sequences the accumulator CPU datapath (instruction ROM, data RAM, ALU, accumulator, output port). It replaces single-cycle decode with an explicit FSM. The FSM handles variable-latency RAM access through a req/ready handshake and multi-cycle ALU operations (MULT/DIV) through start/done. It also provides run/step control for debug and a bus-timeout halt.

Parameters:
DATA_BITS, 8, opcode and data width (matches `DATA_BITS)
ADDR_BITS, 8, program-counter and RAM address width (matches `ADDR_BITS)
MEM_TIMEOUT, 16, maximum cycles in MEM waiting for mem_ready before bus error
CNT_BITS, 16, width of retired-instruction counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  level; 1 = free-running execution
step  in  1  single-cycle pulse; executes exactly one instruction while run=0
rom_addr  out  ADDR_BITS  program counter driven to ROM
rom_data  in  DATA_BITS+ADDR_BITS  {opcode, operand}, combinational from ROM
mem_req  out  1  RAM access request, held until mem_ready
mem_we  out  1  1 = write (STO), valid with mem_req
mem_addr  out  ADDR_BITS  RAM address, valid with mem_req
mem_ready  in  1  RAM access complete this cycle
alu_op  out  DATA_BITS  latched opcode to ALU
alu_start  out  1  one-cycle pulse starting the ALU operation
alu_done  in  1  ALU result valid this cycle
acc_load  out  1  one-cycle pulse loading the accumulator
acc_src  out  1  0 = RAM read data, 1 = ALU result; valid with acc_load
port_load  out  1  one-cycle pulse loading port_out from the accumulator
state_out  out  3  current FSM state encoding
illegal_op  out  1  one-cycle pulse on an undefined opcode
bus_error  out  1  sticky; set on mem_ready timeout
retired  out  CNT_BITS  count of completed instructions, wraps

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, ir=0, retired=0, bus_error=0. All pulse and request outputs are 0. An in-flight mem_req drops immediately.
- IDLE: if run=1 or step=1 -> FETCH, else stay. A step pulse is latched as a pending step so that exactly one instruction executes.
- FETCH (1 cycle): ir <= rom_data -> DECODE.
- DECODE (1 cycle):
  - JUMP: pc <= operand -> RETIRE.
  - OUT: port_load=1 -> RETIRE.
  - LDA, STO, SUM, SUB, MULT, DIV, AND, OR, XOR: mem_req=1, mem_addr=operand, mem_we=(STO) -> MEM. The timeout counter is cleared.
  - Any other opcode: illegal_op=1, treated as NOP -> RETIRE.
- MEM: mem_req/mem_we/mem_addr are held stable until mem_ready.
  - On mem_ready, STO -> RETIRE.
  - On mem_ready, LDA: acc_load=1, acc_src=0 -> RETIRE.
  - On mem_ready, ALU op: alu_start=1 (same cycle) -> ALU.
  - If mem_ready is not seen within MEM_TIMEOUT cycles: bus_error <= 1, mem_req <= 0 -> HALT.
- ALU: wait for alu_done; on alu_done, acc_load=1, acc_src=1 -> RETIRE. An alu_done arriving in the same cycle as alu_start is ignored; completion is sampled from the cycle after start.
- RETIRE (1 cycle): pc <= pc+1 unless the instruction was JUMP; retired <= retired+1.
  - If run=1 -> FETCH, else -> IDLE (the step is consumed).
- HALT: terminal; only reset exits. Outputs are idle; pc is frozen for inspection.
- pc increment is modulo 2^ADDR_BITS (0xFF -> 0x00). retired wraps at 2^CNT_BITS.
- Minimum latency per instruction:
  - JUMP/OUT: 3 cycles.
  - LDA/STO: 4 cycles plus RAM wait.
  - ALU ops: 5 cycles plus RAM and ALU wait.
- run deasserted mid-instruction: the current instruction completes, then the FSM returns to IDLE.
- step asserted while run=1 is ignored.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM=3, ALU=4, RETIRE=5, HALT=6.

Decomposition:
- Opcode macros come from the shared defines (`LDA, `STO, `SUM, `SUB, `MULT, `DIV, `AND, `OR, `XOR, `OUT, `JUMP).
- A shared cpu_pkg holds the seq_state_t enum, the opcode-class enum (OPC_JUMP, OPC_OUT, OPC_MEMRD, OPC_MEMWR, OPC_ALU, OPC_ILLEGAL) and the MEM_TIMEOUT default.
- One sub-module, opcode_classifier, is a purely combinational opcode -> class mapping. It is reused by the verification scoreboard.

Test Plan:
- Reset in MEM with mem_req=1, asserted asynchronously mid-cycle -> mem_req=0 before the next edge; state_out=0, rom_addr=0x00, retired=0.
- run=1; ROM[0]=LDA 0x10; mem_ready after 3 wait cycles -> acc_load with acc_src=0 exactly once; rom_addr=0x01; retired=1; 7 cycles from FETCH to next FETCH.
- ROM[0]=DIV 0x20; mem_ready immediate; alu_done 8 cycles after alu_start -> single alu_start pulse; acc_load with acc_src=1 on the alu_done cycle; mem_req low during ALU.
- ROM[0]=JUMP 0xFF; ROM[0xFF]=OUT -> rom_addr 0xFF, then port_load pulse, then rom_addr wraps to 0x00.
- STO 0x05 with mem_ready held 0 -> mem_req high for 16 cycles; bus_error=1; state_out=6; remains until reset.
- run=0; two step pulses 20 cycles apart; opcode 0xEE at ROM[0] -> illegal_op pulse; exactly two instructions retire; state_out=0 between steps.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: shared types and constants for the accumulator CPU
// control unit.
//   seq_state_t  - sequencer FSM states; the encoding is visible on state_out
//   opc_class_t  - opcode classes produced by opcode_classifier
//   OP_*         - instruction opcodes (upper byte of a ROM word)
//   MEM_TIMEOUT_DEFAULT - cycles allowed in MEM before a bus error
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        ALU    = 3'd4,
        RETIRE = 3'd5,
        HALT   = 3'd6
    } seq_state_t;

    typedef enum logic [2:0] {
        OPC_JUMP,
        OPC_OUT,
        OPC_MEMRD,
        OPC_MEMWR,
        OPC_ALU,
        OPC_ILLEGAL
    } opc_class_t;

    localparam int MEM_TIMEOUT_DEFAULT = 16;

    localparam logic [7:0] OP_LDA  = 8'h01;
    localparam logic [7:0] OP_STO  = 8'h02;
    localparam logic [7:0] OP_SUM  = 8'h03;
    localparam logic [7:0] OP_SUB  = 8'h04;
    localparam logic [7:0] OP_MULT = 8'h05;
    localparam logic [7:0] OP_DIV  = 8'h06;
    localparam logic [7:0] OP_AND  = 8'h07;
    localparam logic [7:0] OP_OR   = 8'h08;
    localparam logic [7:0] OP_XOR  = 8'h09;
    localparam logic [7:0] OP_OUT  = 8'h0A;
    localparam logic [7:0] OP_JUMP = 8'h0B;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: RAM request/ready bus plus ALU start/done handshake.
//   master (sequencer): drives mem_req, mem_we, mem_addr, alu_op, alu_start;
//                       samples mem_ready, alu_done
//   slave  (datapath) : the mirror image
interface cpu_sequencer_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
) ();

    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_ready;
    logic [DATA_BITS-1:0] alu_op;
    logic                 alu_start;
    logic                 alu_done;

    modport master (
        output mem_req, mem_we, mem_addr, alu_op, alu_start,
        input  mem_ready, alu_done
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, alu_op, alu_start,
        output mem_ready, alu_done
    );

endinterface

// File: rtl/cpu_sequencer_opcode_classifier.sv
// opcode_classifier: purely combinational opcode -> instruction class map.
//   opcode    in  DATA_BITS  instruction opcode
//   opc_class out            class (jump, out, memory read/write, ALU, illegal)
module opcode_classifier
    import cpu_sequencer_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic [DATA_BITS-1:0] opcode,
    output opc_class_t           opc_class
);

    always_comb begin
        opc_class = OPC_ILLEGAL;
        case (opcode)
            DATA_BITS'(OP_JUMP): opc_class = OPC_JUMP;
            DATA_BITS'(OP_OUT):  opc_class = OPC_OUT;
            DATA_BITS'(OP_LDA):  opc_class = OPC_MEMRD;
            DATA_BITS'(OP_STO):  opc_class = OPC_MEMWR;
            DATA_BITS'(OP_SUM),
            DATA_BITS'(OP_SUB),
            DATA_BITS'(OP_MULT),
            DATA_BITS'(OP_DIV),
            DATA_BITS'(OP_AND),
            DATA_BITS'(OP_OR),
            DATA_BITS'(OP_XOR):  opc_class = OPC_ALU;
            default:             opc_class = OPC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the accumulator CPU.
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   run, step         free-run level / single-instruction pulse (run=0 only)
//   rom_addr/rom_data program counter out, {opcode, operand} in
//   bus               RAM req/ready and ALU start/done handshakes (master)
//   acc_load/acc_src  accumulator load pulse, source 0=RAM 1=ALU
//   port_load         output-port load pulse
//   state_out         FSM state encoding
//   illegal_op        pulse on an undefined opcode (executed as NOP)
//   bus_error         sticky, set when RAM never answers; FSM halts
//   retired           wrapping count of completed instructions
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int ADDR_BITS   = 8,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_BITS    = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           run,
    input  logic                           step,
    output logic [ADDR_BITS-1:0]           rom_addr,
    input  logic [DATA_BITS+ADDR_BITS-1:0] rom_data,
    cpu_sequencer_if.master                bus,
    output logic                           acc_load,
    output logic                           acc_src,
    output logic                           port_load,
    output logic [2:0]                     state_out,
    output logic                           illegal_op,
    output logic                           bus_error,
    output logic [CNT_BITS-1:0]            retired
);

    localparam int TMO_BITS = $clog2(MEM_TIMEOUT + 1);

    seq_state_t                     state, state_nx;
    logic [ADDR_BITS-1:0]           pc;
    logic [DATA_BITS+ADDR_BITS-1:0] ir;
    logic [TMO_BITS-1:0]            tmo_cnt;
    logic [DATA_BITS-1:0]           ir_op;
    logic [ADDR_BITS-1:0]           ir_operand;
    opc_class_t                     opc_class;
    logic                           is_mem;
    logic                           mem_timeout;

    assign ir_op      = ir[DATA_BITS+ADDR_BITS-1 -: DATA_BITS];
    assign ir_operand = ir[ADDR_BITS-1:0];

    opcode_classifier #(.DATA_BITS(DATA_BITS)) u_classify (
        .opcode    (ir_op),
        .opc_class (opc_class)
    );

    assign is_mem = (opc_class == OPC_MEMRD) || (opc_class == OPC_MEMWR) ||
                    (opc_class == OPC_ALU);

    // The request is a pure function of state and ir, so it is stable for the
    // whole MEM wait and falls the instant reset forces the state to IDLE.
    assign bus.mem_req  = (state == MEM) || ((state == DECODE) && is_mem);
    assign bus.mem_we   = bus.mem_req && (opc_class == OPC_MEMWR);
    assign bus.mem_addr = ir_operand;
    assign bus.alu_op   = ir_op;

    assign rom_addr  = pc;
    assign state_out = state;

    // tmo_cnt counts MEM cycles from 0, so the last allowed cycle is
    // MEM_TIMEOUT-1; a ready on that cycle is still accepted.
    assign mem_timeout = (state == MEM) && !bus.mem_ready &&
                         (tmo_cnt == TMO_BITS'(MEM_TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Leaving IDLE on a step is what latches it: with run=0 RETIRE always
    // returns to IDLE, so one step yields exactly one instruction.
    always_comb begin
        state_nx      = state;
        acc_load      = 1'b0;
        acc_src       = 1'b0;
        port_load     = 1'b0;
        illegal_op    = 1'b0;
        bus.alu_start = 1'b0;
        case (state)
            IDLE: begin
                if (run || step) state_nx = FETCH;
            end
            FETCH: state_nx = DECODE;
            DECODE: begin
                case (opc_class)
                    OPC_JUMP: state_nx = RETIRE;
                    OPC_OUT: begin
                        port_load = 1'b1;
                        state_nx  = RETIRE;
                    end
                    OPC_MEMRD, OPC_MEMWR, OPC_ALU: state_nx = MEM;
                    default: begin
                        illegal_op = 1'b1;
                        state_nx   = RETIRE;
                    end
                endcase
            end
            MEM: begin
                if (bus.mem_ready) begin
                    if (opc_class == OPC_ALU) begin
                        bus.alu_start = 1'b1;
                        state_nx      = ALU;
                    end else begin
                        acc_load = (opc_class == OPC_MEMRD);
                        state_nx = RETIRE;
                    end
                end else if (mem_timeout) begin
                    state_nx = HALT;
                end
            end
            // alu_done is only looked at here, so a done coincident with
            // alu_start (still in MEM) is never taken as completion.
            ALU: begin
                if (bus.alu_done) begin
                    acc_load = 1'b1;
                    acc_src  = 1'b1;
                    state_nx = RETIRE;
                end
            end
            RETIRE: state_nx = run ? FETCH : IDLE;
            HALT:   state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            ir        <= '0;
            retired   <= '0;
            bus_error <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                FETCH: ir <= rom_data;
                DECODE: begin
                    tmo_cnt <= '0;
                    if (opc_class == OPC_JUMP) pc <= ir_operand;
                end
                MEM: begin
                    tmo_cnt <= tmo_cnt + TMO_BITS'(1);
                    if (mem_timeout) bus_error <= 1'b1;
                end
                RETIRE: begin
                    if (opc_class != OPC_JUMP) pc <= pc + ADDR_BITS'(1);
                    retired <= retired + CNT_BITS'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed stimulus with an event scoreboard. Each test
// queues the handshake/pulse events it expects; a negedge monitor pops and
// compares every event the sequencer actually produces.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_MEM = 3'd3, ST_ALU = 3'd4, ST_HALT = 3'd6;
    localparam logic [2:0] ST_RETIRE = 3'd5;
    localparam int EV_START = 0, EV_ACC = 1, EV_PORT = 2, EV_ILL = 3, EV_RET = 4;

    typedef struct {
        int          kind;
        logic [15:0] val;
    } ev_t;

    logic        clock, reset, run, step;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        acc_load, acc_src, port_load, illegal_op, bus_error;
    logic [2:0]  state_out;
    logic [15:0] retired;

    logic [15:0] rom [0:255];
    logic [7:0]  mem_lat, alu_lat;
    logic        mem_never, alu_early;
    logic [7:0]  wcnt = 8'd0;
    logic [7:0]  acnt = 8'd0;
    logic        early_q = 1'b0;

    ev_t exp_q[$];
    int  errors, checks;

    cpu_sequencer_if #(.DATA_BITS(8), .ADDR_BITS(8)) bus ();

    cpu_sequencer #(.DATA_BITS(8), .ADDR_BITS(8), .MEM_TIMEOUT(16), .CNT_BITS(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .bus        (bus),
        .acc_load   (acc_load),
        .acc_src    (acc_src),
        .port_load  (port_load),
        .state_out  (state_out),
        .illegal_op (illegal_op),
        .bus_error  (bus_error),
        .retired    (retired)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign rom_data = rom[rom_addr];

    // RAM answers after mem_lat wait cycles in MEM; ALU answers alu_lat
    // cycles after alu_start, optionally with a stray done in the start cycle.
    assign bus.mem_ready = (state_out == ST_MEM) && !mem_never && (wcnt == mem_lat);
    assign bus.alu_done  = ((acnt != 8'd0) && (acnt == alu_lat)) || early_q;

    always @(posedge clock) begin
        if ((state_out == ST_MEM) && !bus.mem_ready) wcnt <= wcnt + 8'd1;
        else wcnt <= 8'd0;
        if (bus.alu_start) acnt <= 8'd1;
        else if (bus.alu_done || (acnt == 8'd0)) acnt <= 8'd0;
        else acnt <= acnt + 8'd1;
        early_q <= alu_early && (state_out == ST_DECODE);
    end

    task automatic sb_check(input int kind, input logic [15:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind=%0d val=%0h, nothing expected", kind, val);
        end else begin
            e = exp_q.pop_front();
            if ((e.kind != kind) || (e.val != val)) begin
                errors++;
                $display("FAIL sb_event: got kind=%0d val=%0h, expected kind=%0d val=%0h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.alu_start) sb_check(EV_START, {8'h00, bus.alu_op});
            if (acc_load) sb_check(EV_ACC, {15'd0, acc_src});
            if (port_load) sb_check(EV_PORT, 16'd0);
            if (illegal_op) sb_check(EV_ILL, 16'd0);
            if (state_out == ST_RETIRE) sb_check(EV_RET, retired);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while ((state_out != s) && (n < budget)) begin
            @(negedge clock);
            n++;
        end
        chk("wait_state", 32'(state_out), 32'(s));
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t_start, t_acc, bad, cnt, nz;
        logic [7:0] addr_at_start;
        errors = 0;
        checks = 0;
        mem_lat = 8'd0;
        alu_lat = 8'd1;
        mem_never = 1'b0;
        alu_early = 1'b0;
        run = 1'b0;
        step = 1'b0;
        reset = 1'b1;
        clear_rom();
        repeat (2) @(negedge clock);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_pc", 32'(rom_addr), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_hold", 32'(state_out), 32'(ST_IDLE));

        // LDA with 3 RAM wait cycles, followed by OUT after run drops
        rom[0] = {OP_LDA, 8'h10};
        rom[1] = {OP_OUT, 8'h00};
        mem_lat = 8'd3;
        push(EV_ACC, 16'd0); push(EV_RET, 16'd0);
        push(EV_PORT, 16'd0); push(EV_RET, 16'd1);
        run = 1'b1;
        wait_state(ST_FETCH, 5, n);
        @(negedge clock);
        wait_state(ST_FETCH, 20, n);
        chk("lda_fetch_to_fetch", 32'(n + 1), 32'd7);
        chk("lda_pc", 32'(rom_addr), 32'h01);
        chk("lda_retired", 32'(retired), 32'd1);
        run = 1'b0;
        wait_state(ST_IDLE, 10, n);
        chk("out_retired", 32'(retired), 32'd2);
        chk("out_pc", 32'(rom_addr), 32'h02);
        chk("t1_drain", 32'(exp_q.size()), 32'd0);

        // DIV: immediate RAM, ALU done 8 cycles after start, stray early done
        do_reset();
        clear_rom();
        rom[0] = {OP_DIV, 8'h20};
        mem_lat = 8'd0;
        alu_lat = 8'd8;
        alu_early = 1'b1;
        push(EV_START, {8'h00, OP_DIV}); push(EV_ACC, 16'd1); push(EV_RET, 16'd0);
        run = 1'b1;
        wait_state(ST_FETCH, 5, n);
        run = 1'b0;
        t_start = -100;
        t_acc = 0;
        bad = 0;
        addr_at_start = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.alu_start) begin
                t_start = c;
                addr_at_start = bus.mem_addr;
            end
            if (acc_load) t_acc = c;
            if ((state_out == ST_ALU) && bus.mem_req) bad++;
            if (state_out == ST_IDLE) break;
        end
        alu_early = 1'b0;
        chk("div_idle", 32'(state_out), 32'(ST_IDLE));
        chk("div_start_to_load", 32'(t_acc - t_start), 32'd8);
        chk("div_mem_addr", 32'(addr_at_start), 32'h20);
        chk("div_mem_req_in_alu", 32'(bad), 32'd0);
        chk("div_retired", 32'(retired), 32'd1);
        chk("t2_drain", 32'(exp_q.size()), 32'd0);

        // JUMP 0xFF then OUT at 0xFF; pc wraps to 0x00
        do_reset();
        clear_rom();
        rom[0] = {OP_JUMP, 8'hFF};
        rom[255] = {OP_OUT, 8'h00};
        push(EV_RET, 16'd0); push(EV_PORT, 16'd0); push(EV_RET, 16'd1);
        run = 1'b1;
        wait_state(ST_FETCH, 5, n);
        @(negedge clock);
        wait_state(ST_FETCH, 10, n);
        chk("jump_latency", 32'(n + 1), 32'd3);
        chk("jump_pc", 32'(rom_addr), 32'hFF);
        run = 1'b0;
        wait_state(ST_IDLE, 10, n);
        chk("wrap_pc", 32'(rom_addr), 32'h00);
        chk("wrap_retired", 32'(retired), 32'd2);
        chk("t3_drain", 32'(exp_q.size()), 32'd0);

        // STO with RAM never ready: timeout, sticky bus error, HALT
        do_reset();
        clear_rom();
        rom[0] = {OP_STO, 8'h05};
        mem_never = 1'b1;
        run = 1'b1;
        wait_state(ST_FETCH, 5, n);
        run = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if ((state_out == ST_MEM) && bus.mem_req && bus.mem_we && (bus.mem_addr == 8'h05)) cnt++;
            if (state_out == ST_HALT) break;
        end
        chk("tmo_req_cycles", 32'(cnt), 32'd16);
        chk("tmo_state", 32'(state_out), 32'(ST_HALT));
        chk("tmo_bus_error", 32'(bus_error), 32'd1);
        chk("tmo_req_dropped", 32'(bus.mem_req), 32'd0);
        run = 1'b1;
        pulse_step();
        repeat (10) @(negedge clock);
        run = 1'b0;
        chk("halt_state", 32'(state_out), 32'(ST_HALT));
        chk("halt_bus_error", 32'(bus_error), 32'd1);
        chk("halt_pc", 32'(rom_addr), 32'h00);
        chk("halt_retired", 32'(retired), 32'd0);
        chk("t4_drain", 32'(exp_q.size()), 32'd0);
        mem_never = 1'b0;

        // Two single steps over undefined opcodes
        do_reset();
        chk("reset_clears_bus_error", 32'(bus_error), 32'd0);
        clear_rom();
        rom[0] = {8'hEE, 8'h00};
        rom[1] = {8'hEE, 8'h00};
        push(EV_ILL, 16'd0); push(EV_RET, 16'd0);
        push(EV_ILL, 16'd0); push(EV_RET, 16'd1);
        pulse_step();
        wait_state(ST_IDLE, 10, n);
        chk("step1_retired", 32'(retired), 32'd1);
        chk("step1_pc", 32'(rom_addr), 32'h01);
        nz = 0;
        repeat (20) begin
            @(negedge clock);
            if (state_out != ST_IDLE) nz++;
        end
        chk("step_gap_idle", 32'(nz), 32'd0);
        pulse_step();
        wait_state(ST_IDLE, 10, n);
        repeat (10) @(negedge clock);
        chk("step2_retired", 32'(retired), 32'd2);
        chk("step2_pc", 32'(rom_addr), 32'h02);
        chk("t5_drain", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a MEM wait
        do_reset();
        clear_rom();
        rom[0] = {OP_JUMP, 8'h40};
        rom[8'h40] = {OP_LDA, 8'h10};
        mem_never = 1'b1;
        push(EV_RET, 16'd0);
        run = 1'b1;
        wait_state(ST_MEM, 20, n);
        chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
        chk("pre_rst_pc", 32'(rom_addr), 32'h40);
        chk("pre_rst_retired", 32'(retired), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_req", 32'(bus.mem_req), 32'd0);
        chk("async_state", 32'(state_out), 32'd0);
        chk("async_pc", 32'(rom_addr), 32'h00);
        chk("async_retired", 32'(retired), 32'd0);
        run = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        mem_never = 1'b0;
        chk("t6_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
